// File: rtl/dice_race_game_ctrl_if.sv
// Dice race controller bundle: menu/dice/renderer inputs and the
// position/turn/winner outputs consumed by the UI generator.
//
// Handshake semantics: confirm and dice_valid are single-cycle strobes
// sampled on the rising clock edge with no back-pressure; turn_done may be
// a pulse or a level; pos_valid is a single-cycle strobe marking a cycle in
// which a position has just changed; winner_valid is a level held while the
// game is won.
//
// Modports:
//   master - drives the inputs of the controller, observes its outputs
//   slave  - the controller side
interface dice_race_game_ctrl_if;
  logic       confirm;
  logic       menu_select;
  logic       dice_valid;
  logic [2:0] dice_value;
  logic       turn_done;
  logic       is_intro_state;
  logic [3:0] p1_pos;
  logic [3:0] p2_pos;
  logic       pos_valid;
  logic       winner_valid;
  logic       turn;
  logic       winner;
  logic [1:0] state_dbg;

  modport master (
    output confirm, menu_select, dice_valid, dice_value, turn_done,
    input  is_intro_state, p1_pos, p2_pos, pos_valid, winner_valid,
           turn, winner, state_dbg
  );

  modport slave (
    input  confirm, menu_select, dice_valid, dice_value, turn_done,
    output is_intro_state, p1_pos, p2_pos, pos_valid, winner_valid,
           turn, winner, state_dbg
  );
endinterface

// File: rtl/dice_race_game_ctrl.sv
// Turn-based dice race game controller.
//
// Sequences INTRO -> (WAIT_ROLL <-> WAIT_ANIM)* -> WIN -> INTRO. Accepts a
// legal dice roll for the active player, advances that player's tile
// (saturating at FINISH_TILE), waits for the renderer's turn_done (or a
// timeout), then either hands the turn over or declares the winner.
//
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset, synchronous release
//   bus      - dice_race_game_ctrl_if.slave: confirm, menu_select,
//              dice_valid, dice_value, turn_done in; is_intro_state,
//              p1_pos, p2_pos, pos_valid, winner_valid, turn, winner,
//              state_dbg (current FSM state) out. All outputs registered.
module dice_race_game_ctrl #(
  parameter int FINISH_TILE  = 15,
  parameter int ANIM_TIMEOUT = 50_000_000,
  parameter int DICE_MAX     = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  dice_race_game_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(ANIM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_TIMEOUT - 1);
  localparam logic [3:0] FINISH = 4'(FINISH_TILE);

  typedef enum logic [1:0] {
    ST_INTRO     = 2'd0,
    ST_WAIT_ROLL = 2'd1,
    ST_WAIT_ANIM = 2'd2,
    ST_WIN       = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [3:0]       p1_q, p1_n;
  logic [3:0]       p2_q, p2_n;
  logic             turn_q, turn_n;
  logic             winner_q, winner_n;
  logic             wv_q, wv_n;
  logic             intro_q, intro_n;
  logic             pv_q, pv_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic [3:0] active_pos;
  logic [4:0] sum;
  logic [3:0] moved_pos;
  logic       roll_ok;
  logic       anim_done;

  assign active_pos = turn_q ? p2_q : p1_q;

  // Five-bit sum so a roll near the finish clamps instead of wrapping.
  assign sum       = {1'b0, active_pos} + {2'b00, bus.dice_value};
  assign moved_pos = (sum > {1'b0, FINISH}) ? FINISH : sum[3:0];

  assign roll_ok   = bus.dice_valid &&
                     (bus.dice_value != 3'd0) &&
                     (bus.dice_value <= 3'(DICE_MAX));

  assign anim_done = bus.turn_done || (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_INTRO;
      p1_q     <= 4'd0;
      p2_q     <= 4'd0;
      turn_q   <= 1'b0;
      winner_q <= 1'b0;
      wv_q     <= 1'b0;
      intro_q  <= 1'b1;
      pv_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state    <= state_n;
      p1_q     <= p1_n;
      p2_q     <= p2_n;
      turn_q   <= turn_n;
      winner_q <= winner_n;
      wv_q     <= wv_n;
      intro_q  <= intro_n;
      pv_q     <= pv_n;
      cnt_q    <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    p1_n     = p1_q;
    p2_n     = p2_q;
    turn_n   = turn_q;
    winner_n = winner_q;
    wv_n     = wv_q;
    intro_n  = intro_q;
    pv_n     = 1'b0;
    cnt_n    = cnt_q;

    case (state)
      ST_INTRO: begin
        // END GAME selection leaves the menu untouched.
        if (bus.confirm && !bus.menu_select) begin
          p1_n    = 4'd0;
          p2_n    = 4'd0;
          turn_n  = 1'b0;
          intro_n = 1'b0;
          state_n = ST_WAIT_ROLL;
        end
      end

      ST_WAIT_ROLL: begin
        // A roll takes priority; turn_done has no meaning here.
        if (roll_ok) begin
          if (turn_q) p2_n = moved_pos;
          else        p1_n = moved_pos;
          pv_n    = 1'b1;
          cnt_n   = '0;
          state_n = ST_WAIT_ANIM;
        end
      end

      ST_WAIT_ANIM: begin
        if (cnt_q != CNT_LAST) cnt_n = cnt_q + 1'b1;
        if (anim_done) begin
          if (active_pos == FINISH) begin
            winner_n = turn_q;
            wv_n     = 1'b1;
            state_n  = ST_WIN;
          end else begin
            turn_n  = ~turn_q;
            state_n = ST_WAIT_ROLL;
          end
        end
      end

      ST_WIN: begin
        if (bus.confirm) begin
          wv_n    = 1'b0;
          p1_n    = 4'd0;
          p2_n    = 4'd0;
          turn_n  = 1'b0;
          intro_n = 1'b1;
          state_n = ST_INTRO;
        end
      end

      default: state_n = ST_INTRO;
    endcase
  end

  assign bus.is_intro_state = intro_q;
  assign bus.p1_pos         = p1_q;
  assign bus.p2_pos         = p2_q;
  assign bus.pos_valid      = pv_q;
  assign bus.winner_valid   = wv_q;
  assign bus.turn           = turn_q;
  assign bus.winner         = winner_q;
  assign bus.state_dbg      = state;

endmodule

// File: doc/dice_race_game_ctrl.md
Name: dice_race_game_ctrl

Overview:
- Turn-based game controller for the dice race; sits directly upstream of the UI generator.
- Consumes the menu confirm, the menu selection and per-roll dice results from the camera dice detector.
- Produces the intro flag, both player tile positions, the active-player turn bit, and the pos_valid / winner_valid strobes the UI renderer consumes.
- Consumes the renderer's turn_done (move animation finished) to sequence turns.

Parameters:
- FINISH_TILE, 15: last tile index; reaching it wins.
- ANIM_TIMEOUT, 50_000_000: max cycles waited for turn_done before advancing anyway.
- DICE_MAX, 6: largest legal dice value.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- confirm  in  1  one-cycle pulse, menu/confirm button (already debounced).
- menu_select  in  1  0 = START GAME, 1 = END GAME; level.
- dice_valid  in  1  one-cycle pulse; dice_value is valid this cycle.
- dice_value  in  3  detected pip count.
- turn_done  in  1  pulse or level from the UI renderer; move animation complete.
- is_intro_state  out  1  high while in the intro menu.
- p1_pos  out  4  player 1 tile index.
- p2_pos  out  4  player 2 tile index.
- pos_valid  out  1  one-cycle pulse; a position just changed.
- winner_valid  out  1  high while the game is won.
- turn  out  1  active player: 0 = P1, 1 = P2.
- winner  out  1  winning player; meaningful only when winner_valid = 1.

Behaviour:
- Reset (async assert, sync release):
  - State INTRO.
  - is_intro_state = 1; p1_pos = p2_pos = 0; turn = 0; winner = 0; pos_valid = 0; winner_valid = 0.
  - Timeout counter = 0.
- All outputs are registered.
- States: INTRO, WAIT_ROLL, WAIT_ANIM, WIN.
- INTRO:
  - confirm with menu_select = 0: clear positions, turn = 0, go to WAIT_ROLL. is_intro_state drops on the next cycle.
  - confirm with menu_select = 1: remain in INTRO; no output changes.
  - dice_valid and turn_done are ignored.
- WAIT_ROLL:
  - Accepts dice_valid only when 1 <= dice_value <= DICE_MAX. Values 0 or 7 are discarded; state unchanged.
  - On an accepted roll at edge N, the active player's position becomes min(pos + dice_value, FINISH_TILE).
  - The sum is computed 5 bits wide, so there is no 4-bit wrap.
  - pos_valid = 1 for exactly the cycle after edge N.
  - Go to WAIT_ANIM; clear the timeout counter.
  - The inactive player's position never changes.
- WAIT_ANIM:
  - dice_valid is ignored, so extra rolls are dropped.
  - turn_done high in any cycle, including the pos_valid cycle, counts as done. So does the counter reaching ANIM_TIMEOUT-1.
  - When done and the active position == FINISH_TILE:
    - go to WIN; winner = turn; winner_valid = 1 from the next cycle.
    - turn is unchanged.
  - When done otherwise: toggle turn and go to WAIT_ROLL.
  - The counter increments every cycle in WAIT_ANIM and saturates.
- WIN:
  - winner_valid held at 1; positions and turn frozen. turn_done and dice_valid are ignored.
  - confirm: go to INTRO; winner_valid = 0; positions = 0; turn = 0; is_intro_state = 1, all on the next cycle.
- Simultaneous events:
  - confirm is ignored in WAIT_ROLL and WAIT_ANIM; there is no abort mid-game.
  - In WAIT_ROLL, dice_valid together with turn_done: the roll is taken and turn_done is ignored.
- Reset asserted mid-game: immediate return to reset values; no pending pos_valid is emitted.
- pos_valid never asserts for two consecutive cycles.

Test Plan:
- Reset, then confirm with menu_select = 1 → is_intro_state stays 1 and all positions stay 0. Then confirm with menu_select = 0 → is_intro_state = 0 one cycle later, turn = 0.
- Roll 4 as P1 → p1_pos = 4 with a single-cycle pos_valid. Then turn_done → turn = 1. Then roll 3 → p2_pos = 3 and p1_pos stays 4.
- dice_value = 0 and dice_value = 7 in WAIT_ROLL → no pos_valid and no position change. A dice_valid during WAIT_ANIM → ignored.
- P1 at 13 rolls 6 → p1_pos = 15 (saturated). Then turn_done → winner_valid = 1, winner = 0, turn stays 0. Then confirm → intro, positions 0.
- Hold turn_done low after a move (ANIM_TIMEOUT set to 8 for sim) → turn toggles exactly 8 cycles after entering WAIT_ANIM.
- Assert reset_n low during WAIT_ANIM with p2_pos = 9 → all outputs return to reset values asynchronously, in the same cycle.
